// File: rtl/scp_loader.sv
// Serial program loader: decodes a framed byte stream, writes it through the SCP
// memory-edit port and holds the CPU in reset until the frame checksum verifies.
module scp_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         EDIT_CYCLES = 2,
    parameter int         TIMEOUT     = 1000
) (
    input  logic       CLK,
    input  logic       AR,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic       RX_READY,
    output logic [7:0] MEM_ADDR,
    output logic [7:0] MEM_DATA,
    output logic       MEM_EDIT,
    output logic       CPU_RST,
    output logic       BUSY,
    output logic       ERR
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_SETTLE,
        S_CHECK,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    sum_q, sum_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    edit_q, edit_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          rx_ready;
    logic          xfer;
    logic          timed;
    logic [7:0]    sum_rx;

    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            state_q   <= S_IDLE;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            sum_q     <= 8'h00;
            cnt_q     <= 9'd0;
            timer_q   <= '0;
            edit_q    <= 4'd0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            edit_q    <= edit_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        edit_d    = edit_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        err_d     = err_q;

        rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_COUNT) ||
                   (state_q == S_DATA) || (state_q == S_CHECK);
        timed    = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                   (state_q == S_DATA) || (state_q == S_CHECK);
        xfer     = RX_VALID && rx_ready;
        sum_rx   = sum_q + RX_DATA;

        case (state_q)
            S_IDLE: begin
                if (xfer && (RX_DATA == SYNC_BYTE)) begin
                    state_d   = S_ADDR;
                    busy_d    = 1'b1;
                    cpu_rst_d = 1'b1;
                    err_d     = 1'b0;
                    sum_d     = 8'h00;
                end
            end
            S_ADDR: begin
                if (xfer) begin
                    addr_d  = RX_DATA;
                    sum_d   = sum_rx;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    // A zero count byte encodes a full 256-byte image.
                    cnt_d   = {(RX_DATA == 8'h00), RX_DATA};
                    sum_d   = sum_rx;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    data_d  = RX_DATA;
                    sum_d   = sum_rx;
                    edit_d  = 4'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (edit_q == 4'(EDIT_CYCLES - 1)) begin
                    state_d = S_SETTLE;
                end else begin
                    edit_d = edit_q + 4'd1;
                end
            end
            S_SETTLE: begin
                addr_d  = addr_q + 8'h01;
                cnt_d   = cnt_q - 9'd1;
                state_d = (cnt_q == 9'd1) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (xfer) begin
                    if (sum_rx == 8'h00) begin
                        state_d = S_RELEASE;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RELEASE: begin
                cpu_rst_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Idle-gap watchdog; the abort overrides any state change above because it only fires without a transfer.
        if (timed) begin
            if (xfer) begin
                timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                timer_d = '0;
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            timer_d = '0;
        end
    end

    assign RX_READY = rx_ready;
    assign MEM_ADDR = addr_q;
    assign MEM_DATA = data_q;
    assign MEM_EDIT = (state_q == S_WRITE);
    assign CPU_RST  = cpu_rst_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_scp_loader.sv
// Self-checking bench for scp_loader: random frames against a frame-level model of
// expected memory writes, checksum verdict, handshake gaps, timeout and async reset.
module tb_scp_loader;

    localparam int EDIT_CYCLES = 2;
    localparam int TIMEOUT     = 1000;

    logic       CLK;
    logic       AR;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic [7:0] MEM_ADDR;
    logic [7:0] MEM_DATA;
    logic       MEM_EDIT;
    logic       CPU_RST;
    logic       BUSY;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    scp_loader #(
        .SYNC_BYTE  (8'hA5),
        .EDIT_CYCLES(EDIT_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .AR      (AR),
        .RX_DATA (RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_READY(RX_READY),
        .MEM_ADDR(MEM_ADDR),
        .MEM_DATA(MEM_DATA),
        .MEM_EDIT(MEM_EDIT),
        .CPU_RST (CPU_RST),
        .BUSY    (BUSY),
        .ERR     (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Observed memory-edit pulses: address/data, pulse length, and whether
    // address/data stayed put through the pulse and the following settle cycle.
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         len;
        bit         stable;
    } wr_t;

    wr_t        cap_q[$];
    int         cur_len = 0;
    logic [7:0] cur_a, cur_d;
    bit         cur_stab;

    always @(negedge CLK) begin
        if (MEM_EDIT === 1'b1) begin
            if (cur_len == 0) begin
                cur_a    = MEM_ADDR;
                cur_d    = MEM_DATA;
                cur_stab = 1'b1;
            end else if (MEM_ADDR !== cur_a || MEM_DATA !== cur_d) begin
                cur_stab = 1'b0;
            end
            cur_len++;
        end else if (cur_len > 0) begin
            if (MEM_ADDR !== cur_a || MEM_DATA !== cur_d) cur_stab = 1'b0;
            cap_q.push_back('{cur_a, cur_d, cur_len, cur_stab});
            cur_len = 0;
        end
    end

    logic [7:0] frame_data[$];

    task automatic send_byte(input logic [7:0] b, output int waits);
        waits = 0;
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (RX_READY !== 1'b1 && waits < 64) begin
            @(negedge CLK);
            waits++;
        end
        checks++;
        if (RX_READY !== 1'b1) begin
            errors++;
            $display("FAIL send_byte: RX_READY stuck at %b for byte %02h, expected 1", RX_READY, b);
        end
        @(posedge CLK);
        #1;
    endtask

    // Sends SYNC,start,count,frame_data,chk and checks every effect against the model.
    // chk_val < 0 selects the correct checksum.
    task automatic run_frame(input logic [7:0] start, input int chk_val, input string name);
        int         n, w, s;
        logic [7:0] chk;
        bit         good;
        bit         bad_gap;
        n = frame_data.size();
        s = int'(start) + (n % 256);
        foreach (frame_data[i]) s += int'(frame_data[i]);
        chk  = (chk_val < 0) ? 8'((256 - (s % 256)) % 256) : 8'(chk_val);
        good = (((s + int'(chk)) % 256) == 0);
        cap_q.delete();

        send_byte(8'hA5, w);
        send_byte(start, w);
        send_byte(8'(n % 256), w);
        bad_gap = 1'b0;
        foreach (frame_data[i]) begin
            send_byte(frame_data[i], w);
            if (i > 0 && w != EDIT_CYCLES + 1) bad_gap = 1'b1;
        end
        send_byte(chk, w);
        if (w != EDIT_CYCLES + 1) bad_gap = 1'b1;
        RX_VALID = 1'b0;

        checks++;
        if (bad_gap) begin
            errors++;
            $display("FAIL %s ready_gap: RX_READY low gap differed from %0d cycles", name, EDIT_CYCLES + 1);
        end
        checks++;
        if (cap_q.size() != n) begin
            errors++;
            $display("FAIL %s write_count: got %0d writes, expected %0d", name, cap_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (cap_q[i].a !== 8'(int'(start) + i) || cap_q[i].d !== frame_data[i] ||
                    cap_q[i].len != EDIT_CYCLES || !cap_q[i].stable) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got a=%02h d=%02h len=%0d stable=%0d, expected a=%02h d=%02h len=%0d stable=1",
                             name, i, cap_q[i].a, cap_q[i].d, cap_q[i].len, cap_q[i].stable,
                             8'(int'(start) + i), frame_data[i], EDIT_CYCLES);
                    break;
                end
            end
        end

        if (good) begin
            checks++;
            if (CPU_RST !== 1'b1 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL %s release_cycle: got CPU_RST=%b BUSY=%b, expected 1 1", name, CPU_RST, BUSY);
            end
            @(posedge CLK);
            #1;
            checks++;
            if (CPU_RST !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0 || RX_READY !== 1'b1) begin
                errors++;
                $display("FAIL %s released: got CPU_RST=%b BUSY=%b ERR=%b RX_READY=%b, expected 0 0 0 1",
                         name, CPU_RST, BUSY, ERR, RX_READY);
            end
        end else begin
            checks++;
            if (CPU_RST !== 1'b1 || BUSY !== 1'b0 || ERR !== 1'b1 || RX_READY !== 1'b1) begin
                errors++;
                $display("FAIL %s bad_chk: got CPU_RST=%b BUSY=%b ERR=%b RX_READY=%b, expected 1 0 1 1",
                         name, CPU_RST, BUSY, ERR, RX_READY);
            end
        end
    endtask

    task automatic fill_random(input int n);
        frame_data.delete();
        for (int i = 0; i < n; i++) frame_data.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic test_reset();
        AR       = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (RX_READY !== 1'b1 || MEM_ADDR !== 8'h00 || MEM_DATA !== 8'h00 || MEM_EDIT !== 1'b0 ||
            CPU_RST !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset: got rdy=%b addr=%02h data=%02h edit=%b cpu_rst=%b busy=%b err=%b, expected 1 00 00 0 0 0 0",
                     RX_READY, MEM_ADDR, MEM_DATA, MEM_EDIT, CPU_RST, BUSY, ERR);
        end
        @(negedge CLK);
        AR = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_good_frame();
        frame_data = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h10, -1, "good_frame");
    endtask

    task automatic test_bad_checksum();
        frame_data = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h10, 8'h00, "bad_checksum");
        fill_random(4);
        run_frame(8'($urandom_range(0, 255)), -1, "recover_after_bad");
    endtask

    task automatic test_wrap();
        fill_random(3);
        run_frame(8'hFE, -1, "addr_wrap");
    endtask

    task automatic test_long_count();
        fill_random(256);
        run_frame(8'($urandom_range(0, 255)), -1, "count_256");
    endtask

    task automatic test_garbage();
        int w;
        cap_q.delete();
        send_byte(8'h00, w);
        send_byte(8'hFF, w);
        RX_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0 || CPU_RST !== 1'b0 || cap_q.size() != 0 || RX_READY !== 1'b1) begin
            errors++;
            $display("FAIL garbage_idle: got BUSY=%b CPU_RST=%b writes=%0d rdy=%b, expected 0 0 0 1",
                     BUSY, CPU_RST, cap_q.size(), RX_READY);
        end
        fill_random(2);
        run_frame(8'h80, -1, "after_garbage");
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 6; k++) begin
            int cv;
            fill_random($urandom_range(1, 8));
            cv = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1;
            run_frame(8'($urandom_range(0, 255)), cv, "random_frame");
        end
    endtask

    task automatic test_timeout();
        int w;
        cap_q.delete();
        send_byte(8'hA5, w);
        send_byte(8'h20, w);
        RX_VALID = 1'b0;
        repeat (TIMEOUT - 1) @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got BUSY=%b one cycle before timeout, expected 1", BUSY);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b0 || CPU_RST !== 1'b1 || cap_q.size() != 0 || cur_len != 0) begin
            errors++;
            $display("FAIL timeout: got ERR=%b BUSY=%b CPU_RST=%b writes=%0d, expected 1 0 1 0",
                     ERR, BUSY, CPU_RST, cap_q.size() + cur_len);
        end
        fill_random(2);
        run_frame(8'h33, -1, "after_timeout");
    endtask

    task automatic test_async_reset();
        int w;
        send_byte(8'hA5, w);
        send_byte(8'h40, w);
        send_byte(8'h02, w);
        send_byte(8'h5A, w);
        checks++;
        if (MEM_EDIT !== 1'b1 || CPU_RST !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got MEM_EDIT=%b CPU_RST=%b in write, expected 1 1", MEM_EDIT, CPU_RST);
        end
        #2 AR = 1'b1;
        #1;
        checks++;
        if (MEM_EDIT !== 1'b0 || CPU_RST !== 1'b0 || BUSY !== 1'b0 || RX_READY !== 1'b1 || MEM_ADDR !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got edit=%b cpu_rst=%b busy=%b rdy=%b addr=%02h, expected 0 0 0 1 00",
                     MEM_EDIT, CPU_RST, BUSY, RX_READY, MEM_ADDR);
        end
        RX_VALID = 1'b0;
        @(negedge CLK);
        AR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        frame_data = '{8'hC3};
        run_frame(8'h07, -1, "after_async_reset");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_wrap();
        test_garbage();
        test_random_frames();
        test_long_count();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
